// File: rtl/gear_selector.sv
// gear_selector: P/R/N/D shift-lever controller with brake/standstill interlocks,
// post-shift lockout window and a sticky reject reason for the dashboard.
module gear_selector #(
   parameter int LOCK_CYCLES = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       engine_on,
   input  logic       shift_up,
   input  logic       shift_down,
   input  logic       is_brake_normal,
   input  logic       is_brake_hard,
   input  logic [7:0] speed,
   output logic [3:0] current_gear,
   output logic       shift_reject,
   output logic [1:0] reject_code,
   output logic       lockout_active
);
   localparam int CW = $clog2(LOCK_CYCLES + 1);
   localparam logic [3:0] P = 4'd3, R = 4'd6, N = 4'd9, D = 4'd12;
   localparam logic [CW-1:0] LOAD = CW'(LOCK_CYCLES);
   logic [3:0] gear_q, gear_d, next_gear;
   logic rej_q, rej_d, up_q, down_q;
   logic [1:0] code_q, code_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic up_e, dn_e, brake, stopped, legal, move, need_stop, need_brake, blocked, reject;
   always_comb begin
      up_e = shift_up & ~up_q & ~(shift_down & ~down_q);
      dn_e = shift_down & ~down_q & ~(shift_up & ~up_q);
      brake = is_brake_normal | is_brake_hard;
      stopped = speed == 8'd0;
      legal = gear_q inside {P, R, N, D};
      next_gear = up_e ? ((gear_q == P) ? R : (gear_q == R) ? N : D)
                       : ((gear_q == D) ? N : (gear_q == N) ? R : P);
      move = legal & ((up_e & gear_q != D) | (dn_e & gear_q != P));
      need_stop = dn_e & (gear_q == N | gear_q == R);
      need_brake = (up_e & gear_q == P) | (dn_e & gear_q == N);
      // a counter at 1 expires on this very edge, so a request sampled now is accepted
      blocked = cnt_q > CW'(1);
      reject = blocked | (need_stop & ~stopped) | (need_brake & ~brake);
      gear_d = legal ? gear_q : P;
      rej_d = 1'b0;
      code_d = code_q;
      cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      if (!engine_on) begin
         gear_d = P;
         cnt_d = '0;
      end else if (move && reject) begin
         rej_d = 1'b1;
         code_d = blocked ? 2'd3 : (need_stop & ~stopped) ? 2'd2 : 2'd1;
      end else if (move) begin
         gear_d = next_gear;
         cnt_d = LOAD;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         gear_q <= P;
         rej_q <= 1'b0;
         code_q <= 2'd0;
         cnt_q <= '0;
         up_q <= 1'b1;
         down_q <= 1'b1;
      end else begin
         gear_q <= gear_d;
         rej_q <= rej_d;
         code_q <= code_d;
         cnt_q <= cnt_d;
         up_q <= shift_up;
         down_q <= shift_down;
      end
   end
   assign current_gear = gear_q;
   assign shift_reject = rej_q;
   assign reject_code = code_q;
   assign lockout_active = cnt_q != '0;
endmodule

// File: tb/tb_gear_selector.sv
// tb_gear_selector: directed and random stimulus against a cycle-indexed gear model,
// compared through a scoreboard queue by an independent monitor.
module tb_gear_selector;
   localparam int L = 4;
   logic clk = 1'b0;
   logic rst = 1'b1, engine_on = 1'b1, shift_up = 1'b0, shift_down = 1'b0;
   logic is_brake_normal = 1'b0, is_brake_hard = 1'b0;
   logic [7:0] speed = 8'd0;
   logic [3:0] current_gear;
   logic shift_reject, lockout_active;
   logic [1:0] reject_code;
   typedef struct {
      int g;
      int rej;
      int code;
      int lock;
   } exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0;
   int codes[4] = '{3, 6, 9, 12};
   int m_g = 0, m_code = 0, m_rej = 0;
   bit m_pu = 1, m_pd = 1, lk_valid = 0;
   longint cyc = 0, lk_at = 0;

   gear_selector #(.LOCK_CYCLES(L)) dut (
      .clk(clk), .rst(rst), .engine_on(engine_on), .shift_up(shift_up),
      .shift_down(shift_down), .is_brake_normal(is_brake_normal),
      .is_brake_hard(is_brake_hard), .speed(speed), .current_gear(current_gear),
      .shift_reject(shift_reject), .reject_code(reject_code),
      .lockout_active(lockout_active)
   );

   always #5 clk = ~clk;

   // Model the next edge from the currently driven inputs, queue the expectation, advance.
   task automatic tick();
      exp_t e;
      bit ue, de, brake;
      int tgt;
      if (rst) begin
         m_g = 0; m_code = 0; m_rej = 0; m_pu = 1; m_pd = 1; lk_valid = 0;
      end else begin
         ue = shift_up && !m_pu;
         de = shift_down && !m_pd;
         m_pu = shift_up;
         m_pd = shift_down;
         brake = is_brake_normal || is_brake_hard;
         m_rej = 0;
         if (!engine_on) begin
            m_g = 0;
            lk_valid = 0;
         end else if (ue != de) begin
            tgt = ue ? m_g + 1 : m_g - 1;
            if (tgt >= 0 && tgt <= 3) begin
               if (lk_valid && cyc < lk_at + L) begin
                  m_rej = 1; m_code = 3;
               end else if (de && (m_g == 1 || m_g == 2) && speed != 0) begin
                  m_rej = 1; m_code = 2;
               end else if (((ue && m_g == 0) || (de && m_g == 2)) && !brake) begin
                  m_rej = 1; m_code = 1;
               end else begin
                  m_g = tgt; lk_at = cyc; lk_valid = 1;
               end
            end
         end
      end
      e.g = codes[m_g];
      e.rej = m_rej;
      e.code = m_code;
      e.lock = (lk_valid && cyc - lk_at < L) ? 1 : 0;
      sb.push_back(e);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_up();
      shift_up = 1'b1; tick(); shift_up = 1'b0; tick();
   endtask

   task automatic pulse_down();
      shift_down = 1'b1; tick(); shift_down = 1'b0; tick();
   endtask

   function automatic void chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, req);
      end
   endfunction

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("current_gear", int'(current_gear), e.g);
            chk("shift_reject", int'(shift_reject), e.rej);
            chk("reject_code", int'(reject_code), e.code);
            chk("lockout_active", int'(lockout_active), e.lock);
         end
      end
   end

   initial begin
      rst = 1'b1; shift_up = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(3);
      shift_up = 1'b0;
      tick();
      pulse_up();
      is_brake_normal = 1'b1;
      shift_up = 1'b1; tick(); shift_up = 1'b0; tick();
      shift_up = 1'b1; tick(); shift_up = 1'b0; tick();
      shift_up = 1'b1; tick(); shift_up = 1'b0; tick();
      is_brake_normal = 1'b0;
      idle(4);
      pulse_up();
      idle(4);
      speed = 8'd40;
      pulse_down();
      idle(4);
      is_brake_hard = 1'b1;
      pulse_down();
      speed = 8'd0;
      pulse_down();
      is_brake_hard = 1'b0;
      idle(4);
      pulse_up();
      idle(4);
      pulse_up();
      engine_on = 1'b0;
      tick();
      pulse_up();
      pulse_down();
      engine_on = 1'b1;
      tick();
      pulse_down();
      is_brake_normal = 1'b1;
      pulse_up();
      idle(4);
      pulse_up();
      idle(4);
      shift_up = 1'b1; shift_down = 1'b1; tick();
      shift_up = 1'b0; shift_down = 1'b0; tick();
      pulse_up();
      idle(4);
      pulse_up();
      idle(4);
      is_brake_normal = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom % 400) == 0;
         engine_on = ($urandom % 50) != 0;
         shift_up = ($urandom % 3) == 0;
         shift_down = ($urandom % 3) == 0;
         is_brake_normal = ($urandom % 3) == 0;
         is_brake_hard = ($urandom % 4) == 0;
         speed = ($urandom % 2) ? 8'd0 : 8'($urandom_range(1, 255));
         tick();
      end
      rst = 1'b0; shift_up = 1'b0; shift_down = 1'b0;
      idle(2);
      repeat (2) @(posedge clk);
      #2;
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
